// File: rtl/pc_sequencer.sv
// pc_sequencer: registered instruction-address sequencer with stall,
// jump, branch and an optional call/return stack (PC_SEQ_STACK_EN).
module pc_sequencer #(
    parameter int AW    = 4,
    parameter int DEPTH = 4,
    parameter int SW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    input  logic          branch,
    input  logic [AW-1:0] branch_off,
    input  logic          call,
    input  logic [AW-1:0] call_addr,
    input  logic          ret,
    output logic [AW-1:0] pc,
    output logic [SW-1:0] sp,
    output logic          ovf,
    output logic          unf
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_n;
    logic [AW-1:0] pc_inc;

    assign pc_inc = pc_q + AW'(1);
    assign pc     = pc_q;

`ifdef PC_SEQ_STACK_EN

    localparam logic [SW-1:0] DMAX = SW'(DEPTH);

    // Indexed by the full count width; entries at DEPTH and above are
    // never written and stay at their reset value.
    logic [AW-1:0] stk [2**SW];
    logic [SW-1:0] sp_q;
    logic [SW-1:0] sp_n;
    logic [SW-1:0] top;
    logic          ovf_q;
    logic          ovf_n;
    logic          unf_q;
    logic          unf_n;
    logic          push;

    assign top = sp_q - SW'(1);
    assign sp  = sp_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

    // One action per edge, highest priority request wins.
    always_comb begin
        pc_n  = pc_inc;
        sp_n  = sp_q;
        ovf_n = ovf_q;
        unf_n = unf_q;
        push  = 1'b0;
        priority case (1'b1)
            stall: pc_n = pc_q;
            ret: begin
                if (sp_q != '0) begin
                    pc_n = stk[top];
                    sp_n = top;
                end else begin
                    unf_n = 1'b1;
                end
            end
            call: begin
                if (sp_q < DMAX) begin
                    push = 1'b1;
                    sp_n = sp_q + SW'(1);
                    pc_n = call_addr;
                end else begin
                    ovf_n = 1'b1;
                end
            end
            jump:    pc_n = jump_addr;
            branch:  pc_n = pc_q + branch_off;
            default: pc_n = pc_inc;
        endcase
    end

    // Return-address storage; a push always stores the wrapped pc+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**SW; i++) stk[i] <= '0;
        end else if (push) begin
            stk[sp_q] <= pc_inc;
        end
    end

    // Stack pointer and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_n;
            ovf_q <= ovf_n;
            unf_q <= unf_n;
        end
    end

`else

    // call/ret fall through to the lower-priority actions.
    logic unused_stack_in;
    assign unused_stack_in = ^{call, ret, call_addr};

    assign sp  = '0;
    assign ovf = 1'b0;
    assign unf = 1'b0;

    // Stall > jump > branch > increment.
    always_comb begin
        pc_n = pc_inc;
        priority case (1'b1)
            stall:   pc_n = pc_q;
            jump:    pc_n = jump_addr;
            branch:  pc_n = pc_q + branch_off;
            default: pc_n = pc_inc;
        endcase
    end

`endif

    // Program counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer against
// a queue-based reference model.
module tb_pc_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int SW    = 3;
    localparam int MASK  = (1 << AW) - 1;
`ifdef PC_SEQ_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          jump = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic          branch = 1'b0;
    logic [AW-1:0] branch_off = '0;
    logic          call = 1'b0;
    logic [AW-1:0] call_addr = '0;
    logic          ret = 1'b0;
    logic [AW-1:0] pc;
    logic [SW-1:0] sp;
    logic          ovf;
    logic          unf;

    int n_chk  = 0;
    int n_fail = 0;

    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump),
        .jump_addr(jump_addr), .branch(branch), .branch_off(branch_off),
        .call(call), .call_addr(call_addr), .ret(ret),
        .pc(pc), .sp(sp), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Drive one cycle of control, advance the model, wait past the edge.
    task automatic cyc(input bit s, input bit r, input bit c, input int ca,
                       input bit j, input int ja, input bit b, input int bo);
        int nxt;
        stall = s; ret = r; call = c; call_addr = AW'(ca);
        jump = j; jump_addr = AW'(ja); branch = b; branch_off = AW'(bo);
        nxt = (m_pc + 1) & MASK;
        if (!s) begin
            if (STACK_EN && r) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_unf = 1; m_pc = nxt; end
            end else if (STACK_EN && c) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back(nxt);
                    m_pc = ca;
                end else begin
                    m_ovf = 1;
                    m_pc = nxt;
                end
            end else if (j) m_pc = ja;
            else if (b) m_pc = (m_pc + bo) & MASK;
            else m_pc = nxt;
        end
        @(posedge clk);
        #1;
        stall = 0; ret = 0; call = 0; jump = 0; branch = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 0;
        #2;
        @(posedge clk);
        #1;
        rst = 1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({pc, sp, ovf, unf} !== '0) begin
            n_fail++;
            $display("FAIL reset: pc=%0d sp=%0d ovf=%0b unf=%0b expected all 0",
                     pc, sp, ovf, unf);
        end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            idle(1);
            n_chk++;
            if (pc !== AW'(i % 16)) begin
                n_fail++;
                $display("FAIL free_run[%0d]: pc=%0d expected %0d", i, pc, i % 16);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        idle(5);
        #2;
        rst = 0;
        #1;
        n_chk++;
        if (pc !== '0 || sp !== '0) begin
            n_fail++;
            $display("FAIL async_reset: pc=%0d sp=%0d expected 0 0", pc, sp);
        end
        @(posedge clk);
        #1;
        rst = 1;
        model_reset();
        idle(1);
        n_chk++;
        if (pc !== 4'd1) begin
            n_fail++;
            $display("FAIL async_reset_first_inc: pc=%0d expected 1", pc);
        end
    endtask

    task automatic test_stall_jump_branch();
        int exp_pc[4] = '{3, 3, 9, 7};
        do_reset();
        idle(3);
        n_chk++;
        if (pc !== AW'(exp_pc[0])) begin
            n_fail++;
            $display("FAIL sjb_start: pc=%0d expected %0d", pc, exp_pc[0]);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (pc !== AW'(exp_pc[1])) begin
            n_fail++;
            $display("FAIL sjb_stall: pc=%0d expected %0d", pc, exp_pc[1]);
        end
        cyc(0, 0, 0, 0, 1, 9, 0, 0);
        n_chk++;
        if (pc !== AW'(exp_pc[2])) begin
            n_fail++;
            $display("FAIL sjb_jump: pc=%0d expected %0d", pc, exp_pc[2]);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 14);
        n_chk++;
        if (pc !== AW'(exp_pc[3])) begin
            n_fail++;
            $display("FAIL sjb_branch: pc=%0d expected %0d", pc, exp_pc[3]);
        end
        cyc(0, 0, 0, 0, 1, 2, 1, 5);
        n_chk++;
        if (pc !== 4'd2) begin
            n_fail++;
            $display("FAIL jump_over_branch: pc=%0d expected 2", pc);
        end
    endtask

`ifdef PC_SEQ_STACK_EN
    task automatic test_nested_calls();
        int exp_pc[4] = '{8, 12, 9, 3};
        int exp_sp[4] = '{1, 2, 1, 0};
        do_reset();
        idle(2);
        cyc(0, 0, 1, 8, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) cyc(0, 0, 1, 12, 0, 0, 0, 0);
            if (i >= 2) cyc(0, 1, 0, 0, 0, 0, 0, 0);
            n_chk++;
            if (pc !== AW'(exp_pc[i]) || sp !== SW'(exp_sp[i])) begin
                n_fail++;
                $display("FAIL nested[%0d]: pc=%0d sp=%0d expected %0d %0d",
                         i, pc, sp, exp_pc[i], exp_sp[i]);
            end
        end
    endtask

    task automatic test_overflow_underflow();
        int tgt[5]    = '{5, 10, 1, 13, 7};
        int c_pc[5]   = '{5, 10, 1, 13, 14};
        int c_sp[5]   = '{1, 2, 3, 4, 4};
        int r_pc[5]   = '{2, 11, 6, 1, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, tgt[i], 0, 0, 0, 0);
            n_chk++;
            if (pc !== AW'(c_pc[i]) || sp !== SW'(c_sp[i]) ||
                ovf !== (i == 4) || unf !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_call[%0d]: pc=%0d sp=%0d ovf=%0b expected %0d %0d %0b",
                         i, pc, sp, ovf, c_pc[i], c_sp[i], i == 4);
            end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0);
            n_chk++;
            if (pc !== AW'(r_pc[i]) || sp !== SW'(i < 4 ? 3 - i : 0) ||
                unf !== (i == 4) || ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL unf_ret[%0d]: pc=%0d sp=%0d unf=%0b ovf=%0b expected %0d %0d %0b 1",
                         i, pc, sp, unf, ovf, r_pc[i], i < 4 ? 3 - i : 0, i == 4);
            end
        end
    endtask

    task automatic test_stall_ret_call();
        do_reset();
        cyc(0, 0, 1, 8, 0, 0, 0, 0);
        cyc(0, 0, 1, 12, 0, 0, 0, 0);
        cyc(1, 1, 1, 4, 0, 0, 0, 0);
        n_chk++;
        if (pc !== 4'd12 || sp !== 3'd2) begin
            n_fail++;
            $display("FAIL stall_ret_call: pc=%0d sp=%0d expected 12 2", pc, sp);
        end
        cyc(0, 1, 1, 4, 0, 0, 0, 0);
        n_chk++;
        if (pc !== 4'd9 || sp !== 3'd1) begin
            n_fail++;
            $display("FAIL ret_over_call: pc=%0d sp=%0d expected 9 1", pc, sp);
        end
        do_reset();
        cyc(0, 0, 0, 0, 1, 15, 0, 0);
        cyc(0, 0, 1, 3, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (pc !== 4'd0 || sp !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_push: pc=%0d sp=%0d expected 0 0", pc, sp);
        end
    endtask
`else
    task automatic test_no_stack();
        do_reset();
        idle(2);
        cyc(0, 0, 1, 8, 0, 0, 0, 0);
        n_chk++;
        if (pc !== 4'd3 || {sp, ovf, unf} !== '0) begin
            n_fail++;
            $display("FAIL nostack_call: pc=%0d sp=%0d expected 3 0", pc, sp);
        end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (pc !== 4'd4 || {sp, ovf, unf} !== '0) begin
            n_fail++;
            $display("FAIL nostack_ret: pc=%0d sp=%0d unf=%0b expected 4 0 0",
                     pc, sp, unf);
        end
        cyc(0, 1, 0, 0, 1, 11, 0, 0);
        n_chk++;
        if (pc !== 4'd11) begin
            n_fail++;
            $display("FAIL nostack_ret_jump: pc=%0d expected 11", pc);
        end
        cyc(0, 0, 1, 6, 0, 0, 1, 2);
        n_chk++;
        if (pc !== 4'd13 || {sp, ovf, unf} !== '0) begin
            n_fail++;
            $display("FAIL nostack_call_branch: pc=%0d expected 13", pc);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0, int'($urandom_range(0, MASK)),
                $urandom_range(0, 5) == 0, int'($urandom_range(0, MASK)),
                $urandom_range(0, 4) == 0, int'($urandom_range(0, MASK)));
            n_chk++;
            if (pc !== AW'(m_pc) || sp !== SW'(m_stk.size()) ||
                ovf !== m_ovf || unf !== m_unf) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%0d sp=%0d ovf=%0b unf=%0b expected %0d %0d %0b %0b",
                         i, pc, sp, ovf, unf, m_pc, m_stk.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_free_run();
        test_async_reset();
        test_stall_jump_branch();
`ifdef PC_SEQ_STACK_EN
        test_nested_calls();
        test_overflow_underflow();
        test_stall_ret_call();
`else
        test_no_stack();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised successor to the 4-bit free-running program counter: a registered instruction-address sequencer with stall, absolute jump, PC-relative branch and a hardware call/return stack. It drives the instruction memory address port and takes its control inputs from the decode stage. One control action is applied per clock edge.

## Interface
Parameters:
- AW, 4: PC and address width in bits. Instruction memory depth is 2^AW.
- DEPTH, 4: return-stack entries. Must be at least 1.
- SW, 3: stack-count width. Must satisfy 2^SW > DEPTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold the PC and the stack this cycle
- jump  in  1  load jump_addr
- jump_addr  in  AW  absolute target
- branch  in  1  add branch_off to the PC
- branch_off  in  AW  two's-complement offset
- call  in  1  push the return address and load call_addr
- call_addr  in  AW  subroutine target
- ret  in  1  pop the stack into the PC
- pc  out  AW  current instruction address (registered)
- sp  out  SW  number of valid stack entries
- ovf  out  1  sticky overflow flag: a call was made when the stack was full
- unf  out  1  sticky underflow flag: a ret was made when the stack was empty

## Operation
- rst low, at any time including mid-operation: pc=0, sp=0, ovf=0, unf=0, all stack entries=0. This is immediate and does not wait for clk.
- Each rising edge with rst high applies exactly one action. Priority, highest first: stall > ret > call > jump > branch > increment. Lower-priority requests in the same cycle are discarded.
- stall: pc, sp and the stack are unchanged. ovf and unf do not change.
- ret with sp>0: pc ← stack[sp-1], sp ← sp-1.
- ret with sp=0: unf ← 1, pc ← pc+1, sp stays 0.
- call with sp<DEPTH: stack[sp] ← pc+1, sp ← sp+1, pc ← call_addr.
- call with sp=DEPTH: ovf ← 1, no push, stack unchanged, pc ← pc+1. The call target is not taken.
- jump: pc ← jump_addr.
- branch: pc ← pc + branch_off, computed modulo 2^AW, with branch_off as a signed value.
- Otherwise: pc ← pc+1 modulo 2^AW. All-ones wraps to 0.
- The pushed return address is also modulo 2^AW. A call at pc=2^AW-1 pushes 0.
- ovf and unf remain set until rst.

## Timing
- Every output is a flop output. There is no combinational path from inputs to outputs.
- Latency is one cycle. A control input sampled at edge N is reflected on pc and sp after edge N.
- Back-to-back call then ret, with no stall between them, returns to the instruction after the call in 2 cycles.
- Control inputs are level signals sampled at the edge. Holding one high for k cycles applies the action k times. For example, holding call high for 3 cycles pushes 3 entries.
- Reset deassertion is synchronous to clk by system convention. The first increment occurs on the first edge with rst high.

## Configuration
- PC_SEQ_STACK_EN defined: the return stack, sp, ovf, unf and call/ret behaviour are as described above.
- PC_SEQ_STACK_EN undefined:
  - No stack storage is built.
  - call and ret are ignored and fall through to the next priority: jump, then branch, then increment.
  - sp, ovf and unf are tied to 0.
  - DEPTH and SW have no effect.

## Test plan
- Reset then free-run, AW=4: pc goes 0,1,…,15,0. An asynchronous rst pulse mid-cycle forces pc=0 immediately, without waiting for an edge.
- At pc=3, one stall cycle, then jump to 9, then branch_off=4'b1110: pc sequence 3,3,9,7. jump and branch both high in one cycle takes the jump.
- Nested calls: call to 8 at pc=2, then call to 12, then ret, ret: pc 2→8→12→9→3. sp goes 0→1→2→1→0.
- DEPTH=4: five consecutive calls, first to 5 from pc=0. sp saturates at 4, ovf=1, and the fifth call advances pc by 1 instead of taking its target. Five rets then return in LIFO order and the fifth sets unf=1.
- Simultaneous stall, ret and call with sp=2: no change to pc or sp. Next cycle ret+call together: pop only, sp=1.
- Build without PC_SEQ_STACK_EN: call to 8 at pc=2 gives pc=3. sp, ovf and unf stay 0 through the entire ret/call sequence.
